masked_xor_arbiter: RTL and testbench
=====================================

Name: masked_xor_arbiter

Overview:
- Shares one sharewise masked-XOR datapath between two requesters.
- Each requester offers a shared operand pair (a, b) over a valid/ready handshake.
- Round-robin arbitration picks one request per cycle. The result c = a ^ b (per share) lands in a single registered output slot, with valid/ready towards the consumer.
- The output register also acts as the glitch/leakage barrier between the arbiter and downstream masked logic.

Parameters:
- NUM_SHARES, 2, number of Boolean shares per operand (>= 2).
- WIDTH, 8, bits per share.

Ports:
- in_clock  input  1  clock, rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_req_valid  input  2  request valid; bit i belongs to requester i.
- out_req_ready  output  2  request accepted this cycle; bit i belongs to requester i.
- in_a0, in_b0  input  NUM_SHARES x WIDTH  requester 0 operands (packed [NUM_SHARES-1:0][WIDTH-1:0]).
- in_a1, in_b1  input  NUM_SHARES x WIDTH  requester 1 operands (same packing).
- out_c  output  NUM_SHARES x WIDTH  shared result.
- out_c_valid  output  1  result slot holds data.
- out_c_src  output  1  index of the requester that produced out_c.
- in_c_ready  input  1  consumer accepts out_c.

Behaviour:
- Reset (asynchronous, active-high): out_c = 0, out_c_valid = 0, out_c_src = 0, priority pointer ptr = 0, out_req_ready = 0.
- Reset mid-operation discards any held result. It takes effect immediately, with no drain.
- Slot state machine:
  - EMPTY (out_c_valid = 0) -> FULL on accept.
  - FULL -> EMPTY when in_c_ready = 1 and no accept.
  - FULL -> FULL when in_c_ready = 1 and accept (back-to-back; throughput 1 per cycle).
  - FULL with in_c_ready = 0 holds out_c, out_c_src and out_c_valid stable.
- slot_free = !out_c_valid | in_c_ready.
- Grant (combinational):
  - Only requester i valid -> grant i.
  - Both valid -> grant ptr.
  - Neither valid -> no grant.
- out_req_ready[i] = slot_free & grant[i]. At most one bit set; zero whenever the slot is not free.
- Accept = slot_free & any valid. On accept:
  - out_c <= a_g ^ b_g.
  - out_c_src <= g.
  - out_c_valid <= 1.
  - ptr <= ~g.
- ptr changes only on accept. A lone requester does not lose its turn to an absent one.
- Latency: 1 cycle from accept to out_c_valid.
- Masking hygiene:
  - Operand selection is AND-gated per requester (the non-granted operand is forced to 0 before the OR merge). No cross-requester share mixing in a mux.
  - On a FULL -> EMPTY transition out_c is cleared to 0. Stale shares are never held.
  - No share of a is ever combined with another share of a. Shares stay domain-separated: share j of c depends only on share j of a and b (plus randomness in the optional feature).
- Requester handshake rule: operands must stay stable while valid is high and ready is low. The block does not register unaccepted requests.
- Simultaneous drain and accept: the new result replaces the old in the same edge. No bubble, no clear.

Optional Feature:
- Macro: MASKED_XOR_ARB_REFRESH_EN.
- When defined:
  - Adds port in_random, input, (NUM_SHARES-1) x WIDTH.
  - On accept, share j (j < NUM_SHARES-1) of the result is XORed with r_j. The last share is XORed with the XOR of all r_j, so the unmasked value is unchanged.
  - in_random is sampled only on accept cycles.
- When undefined: in_random is absent and the result is the plain sharewise XOR.

Decomposition:
- dev_package holds:
  - Default constants for NUM_SHARES and WIDTH.
  - A localparam for the requester count (2).
  - A requester-index typedef (1 bit) used for ptr and out_c_src.
- Sub-module rr_arbiter_2: two-way round-robin arbiter.
  - Inputs: valid[1:0], advance.
  - Outputs: one-hot grant, ptr register.
  - Async reset on in_reset.
- Datapath, slot register and clear logic stay in masked_xor_arbiter.

Test Plan (NUM_SHARES = 2, WIDTH = 8):
- Single request: req0 valid, a0 = {0x3C, 0x5A}, b0 = {0x0F, 0xF0}, in_c_ready = 1.
  - Cycle 0: out_req_ready = 2'b01.
  - Cycle 1: out_c = {0x33, 0xAA}, out_c_valid = 1, out_c_src = 0.
  - Cycle 2: out_c = 0, out_c_valid = 0.
- Contention: both valid continuously, in_c_ready = 1. Grants alternate 0, 1, 0, 1 starting at 0 after reset; out_c_src follows the same sequence; one result per cycle.
- Backpressure: result pending, in_c_ready = 0 for 3 cycles with both requests valid.
  - out_req_ready = 0 and out_c is held for all 3 cycles.
  - The cycle in_c_ready rises, the next request is accepted and appears 1 cycle later.
- Lone requester fairness: only req1 valid for 4 accepts. All 4 are granted to 1, ptr = 0 afterwards, and the next contention grants 0.
- Reset mid-operation: assert in_reset while out_c_valid = 1 and out_c = {0x11, 0x22}. All outputs go to 0 without waiting for a clock edge; ptr returns to 0.
- Refresh (with MASKED_XOR_ARB_REFRESH_EN): a0 = {0x3C, 0x5A}, b0 = {0x0F, 0xF0}, in_random = 0x77 → out_c = {0x44, 0xDD}; the XOR of the two shares is 0x99, unchanged.

Source files
------------

// File: rtl/dev_package.sv
// Shared constants and types for the masked XOR arbiter.
// Imported by masked_xor_arbiter and rr_arbiter_2.
package dev_package;

    localparam int DEF_NUM_SHARES = 2;
    localparam int DEF_WIDTH      = 8;
    localparam int NUM_REQ        = 2;

    typedef logic req_idx_t;

endpackage

// File: rtl/masked_xor_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter with one-hot grant.
// The priority pointer moves only when a grant is consumed.
module rr_arbiter_2
    import dev_package::*;
(
    input  logic           in_clock,
    input  logic           in_reset,
    input  logic [1:0]     in_valid,
    input  logic           in_advance,
    output logic [1:0]     out_grant,
    output req_idx_t       out_ptr
);

    req_idx_t r_ptr;

    // Lone requester always wins; on contention the pointer decides.
    always_comb begin
        out_grant = 2'b00;
        unique case (in_valid)
            2'b01:   out_grant = 2'b01;
            2'b10:   out_grant = 2'b10;
            2'b11:   out_grant = r_ptr ? 2'b10 : 2'b01;
            default: out_grant = 2'b00;
        endcase
    end

    // Point away from the requester just served.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_ptr <= 1'b0;
        end else if (in_advance) begin
            r_ptr <= ~out_grant[1];
        end
    end

    assign out_ptr = r_ptr;

endmodule

// File: rtl/masked_xor_arbiter.sv
// Two-requester arbiter feeding one sharewise masked-XOR result slot.
// Optional share refresh on accept: MASKED_XOR_ARB_REFRESH_EN.
module masked_xor_arbiter
    import dev_package::*;
#(
    parameter int NUM_SHARES = DEF_NUM_SHARES,
    parameter int WIDTH      = DEF_WIDTH
)
(
    input  logic                              in_clock,
    input  logic                              in_reset,
    input  logic [NUM_REQ-1:0]                in_req_valid,
    output logic [NUM_REQ-1:0]                out_req_ready,
    input  logic [NUM_SHARES-1:0][WIDTH-1:0]  in_a0,
    input  logic [NUM_SHARES-1:0][WIDTH-1:0]  in_b0,
    input  logic [NUM_SHARES-1:0][WIDTH-1:0]  in_a1,
    input  logic [NUM_SHARES-1:0][WIDTH-1:0]  in_b1,
    output logic [NUM_SHARES-1:0][WIDTH-1:0]  out_c,
    output logic                              out_c_valid,
    output logic                              out_c_src,
    input  logic                              in_c_ready
`ifdef MASKED_XOR_ARB_REFRESH_EN
    ,
    input  logic [NUM_SHARES-2:0][WIDTH-1:0]  in_random
`endif
);

    localparam int TOTAL = NUM_SHARES * WIDTH;

    logic [1:0]                       w_grant;
    req_idx_t                         w_ptr_unused;
    logic                             w_slot_free;
    logic                             w_accept;
    logic [NUM_SHARES-1:0][WIDTH-1:0] w_a;
    logic [NUM_SHARES-1:0][WIDTH-1:0] w_b;
    logic [NUM_SHARES-1:0][WIDTH-1:0] w_mask;
    logic [NUM_SHARES-1:0][WIDTH-1:0] w_c;

    logic [NUM_SHARES-1:0][WIDTH-1:0] r_c;
    logic                             r_c_valid;
    req_idx_t                         r_c_src;

    // Reset also blocks handshakes so nothing is acknowledged while held.
    assign w_slot_free   = !in_reset && (!r_c_valid || in_c_ready);
    assign w_accept      = w_slot_free && (|in_req_valid);
    assign out_req_ready = w_grant & {2{w_slot_free}};

    rr_arbiter_2 u_arb (
        .in_clock   (in_clock),
        .in_reset   (in_reset),
        .in_valid   (in_req_valid),
        .in_advance (w_accept),
        .out_grant  (w_grant),
        .out_ptr    (w_ptr_unused)
    );

    // AND-gate each requester before the OR merge: no share-mixing mux.
    assign w_a = (in_a0 & {TOTAL{w_grant[0]}})
               | (in_a1 & {TOTAL{w_grant[1]}});
    assign w_b = (in_b0 & {TOTAL{w_grant[0]}})
               | (in_b1 & {TOTAL{w_grant[1]}});

`ifdef MASKED_XOR_ARB_REFRESH_EN
    logic [WIDTH-1:0] w_last;

    // Fresh mask per share; last share absorbs all so the secret is kept.
    always_comb begin
        w_mask = '0;
        w_last = '0;
        for (int j = 0; j < NUM_SHARES - 1; j++) begin
            w_mask[j] = in_random[j];
            w_last    = w_last ^ in_random[j];
        end
        w_mask[NUM_SHARES-1] = w_last;
    end
`else
    assign w_mask = '0;
`endif

    assign w_c = w_a ^ w_b ^ w_mask;

    // Result slot: load on accept, clear on drain, hold under backpressure.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_c       <= '0;
            r_c_valid <= 1'b0;
            r_c_src   <= 1'b0;
        end else if (w_accept) begin
            r_c       <= w_c;
            r_c_valid <= 1'b1;
            r_c_src   <= w_grant[1];
        end else if (in_c_ready) begin
            r_c       <= '0;
            r_c_valid <= 1'b0;
        end
    end

    assign out_c       = r_c;
    assign out_c_valid = r_c_valid;
    assign out_c_src   = r_c_src;

endmodule

// File: tb/tb_masked_xor_arbiter.sv
// Randomized bench for masked_xor_arbiter against a behavioural model.
// Refresh build: define MASKED_XOR_ARB_REFRESH_EN for DUT and bench.
module tb_masked_xor_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic [15:0] a0, b0, a1, b1;
    logic [15:0] c;
    logic        cv, csrc, cr;
    logic [7:0]  rnd;

    always #5 clk = ~clk;

    masked_xor_arbiter dut (
        .in_clock      (clk),
        .in_reset      (rst),
        .in_req_valid  (vld),
        .out_req_ready (rdy),
        .in_a0         (a0),
        .in_b0         (b0),
        .in_a1         (a1),
        .in_b1         (b1),
        .out_c         (c),
        .out_c_valid   (cv),
        .out_c_src     (csrc),
        .in_c_ready    (cr)
`ifdef MASKED_XOR_ARB_REFRESH_EN
        ,
        .in_random     (rnd)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: whose turn, slot contents, last winner.
    int          m_turn;
    bit          m_full;
    logic [15:0] m_c;
    int          m_src;
    int          last_g;

    task automatic model_reset();
        m_turn = 0;
        m_full = 0;
        m_c    = '0;
        m_src  = 0;
        last_g = -1;
    endtask

    function automatic logic [15:0] masked_result(input logic [15:0] a,
                                                  input logic [15:0] b,
                                                  input logic [7:0] r);
`ifdef MASKED_XOR_ARB_REFRESH_EN
        return a ^ b ^ {r, r};
`else
        return a ^ b;
`endif
    endfunction

    // One cycle: drive, check against model, clock, advance model.
    task automatic step(input logic [1:0] v,
                        input logic [15:0] ia0, input logic [15:0] ib0,
                        input logic [15:0] ia1, input logic [15:0] ib1,
                        input logic icr, input logic [7:0] ir);
        bit   free;
        int   g;
        logic [1:0] exp_rdy;
        @(negedge clk);
        vld = v; a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
        cr = icr; rnd = ir;
        #1;
        free = !m_full || icr;
        g = -1;
        if (free) begin
            if (v == 2'b11) g = m_turn;
            else if (v == 2'b01) g = 0;
            else if (v == 2'b10) g = 1;
        end
        exp_rdy = 2'b00;
        if (g == 0) exp_rdy = 2'b01;
        if (g == 1) exp_rdy = 2'b10;
        check("req_ready", rdy, exp_rdy);
        check("c_valid", cv, m_full);
        check("c", c, m_c);
        if (m_full) check("c_src", csrc, m_src);
        @(posedge clk);
        if (g >= 0) begin
            m_c    = (g == 0) ? masked_result(ia0, ib0, ir)
                              : masked_result(ia1, ib1, ir);
            m_src  = g;
            m_full = 1;
            m_turn = 1 - g;
        end else if (icr) begin
            m_full = 0;
            m_c    = '0;
        end
        last_g = g;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld = 2'b11;
        #1;
        check("rst_c", c, 16'h0);
        check("rst_valid", cv, 1'b0);
        check("rst_src", csrc, 1'b0);
        check("rst_ready", rdy, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        vld = 2'b00;
        model_reset();
    endtask

    logic [1:0]  hv;
    logic [15:0] ha0, hb0, ha1, hb1;

    initial begin
        rst = 1'b1;
        vld = 2'b11;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        cr = 1'b0; rnd = '0;
        model_reset();
        #1;
        check("init_c", c, 16'h0);
        check("init_valid", cv, 1'b0);
        check("init_ready", rdy, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        vld = 2'b00;

        // Single request
        step(2'b01, 16'h3C5A, 16'h0FF0, 16'h0, 16'h0, 1'b1, 8'h77);
        #1;
`ifdef MASKED_XOR_ARB_REFRESH_EN
        check("single_c", c, 16'h44DD);
        check("single_unmasked", c[15:8] ^ c[7:0], 8'h99);
`else
        check("single_c", c, 16'h33AA);
`endif
        check("single_valid", cv, 1'b1);
        check("single_src", csrc, 1'b0);
        step(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 8'h00);
        #1;
        check("single_clear_c", c, 16'h0);
        check("single_clear_v", cv, 1'b0);

        // Contention from a fresh pointer
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 16'h1000 + 16'(i), 16'h0101, 16'h2000 + 16'(i),
                 16'h0202, 1'b1, 8'(i));
            #1;
            check("contend_src", csrc, 32'(i % 2));
        end

        // Backpressure with both requesters waiting
        for (int i = 0; i < 3; i++)
            step(2'b11, 16'hAAAA, 16'h5555, 16'hBBBB, 16'h4444, 1'b0, 8'h13);
        step(2'b11, 16'hAAAA, 16'h5555, 16'hBBBB, 16'h4444, 1'b1, 8'h13);
        step(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 8'h00);

        // Lone requester 1, then contention must favour 0
        for (int i = 0; i < 4; i++) begin
            step(2'b10, 16'h0, 16'h0, 16'h0F00 + 16'(i), 16'h00F0, 1'b1, 8'h21);
            #1;
            check("lone_src", csrc, 1'b1);
        end
        step(2'b11, 16'h1234, 16'h4321, 16'h5678, 16'h8765, 1'b1, 8'h5A);
        #1;
        check("after_lone_src", csrc, 1'b0);

        // Reset while a result is held
        step(2'b01, 16'h1122, 16'h0000, 16'h0, 16'h0, 1'b1, 8'h00);
        @(negedge clk);
        vld = 2'b11;
        cr = 1'b0;
        #1;
        check("pre_rst_c", c, 16'h1122);
        check("pre_rst_valid", cv, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_c", c, 16'h0);
        check("mid_rst_valid", cv, 1'b0);
        check("mid_rst_src", csrc, 1'b0);
        check("mid_rst_ready", rdy, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        vld = 2'b00;
        model_reset();
        step(2'b11, 16'h0F0F, 16'h0, 16'hF0F0, 16'h0, 1'b1, 8'h00);
        #1;
        check("post_rst_src", csrc, 1'b0);

        // Randomized traffic honouring the hold-until-ready rule
        hv = 2'b00;
        ha0 = '0; hb0 = '0; ha1 = '0; hb1 = '0;
        last_g = -1;
        for (int n = 0; n < 400; n++) begin
            if (!hv[0] || last_g == 0) begin
                hv[0] = ($urandom_range(0, 3) != 0);
                ha0 = 16'($urandom);
                hb0 = 16'($urandom);
            end
            if (!hv[1] || last_g == 1) begin
                hv[1] = ($urandom_range(0, 3) != 0);
                ha1 = 16'($urandom);
                hb1 = 16'($urandom);
            end
            step(hv, ha0, hb0, ha1, hb1, ($urandom_range(0, 3) != 0),
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
